// File: rtl/common.sv
// Shared constants and types for the SAT solver clause store and evaluator.
package common;

  localparam int number_literal = 30;

  typedef enum logic [1:0] {
    CSE_IDLE = 2'd0,
    CSE_LOAD = 2'd1,
    CSE_SCAN = 2'd2,
    CSE_DONE = 2'd3
  } cse_state_t;

  typedef struct packed {
    logic [number_literal-1:0] pos;
    logic [number_literal-1:0] neg;
  } clause_t;

endpackage

// File: rtl/clause_lane_eval.sv
// Combinational test of LANES clauses against one assignment: any-fail flag and lowest failing lane.
// The lowest-lane encoder exists only when CLAUSE_FAIL_IDX_EN is defined.
module clause_lane_eval import common::*; #(
  parameter int NUM_LIT = number_literal,
  parameter int LANES = 1,
  localparam int OW = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic [NUM_LIT-1:0] pos [LANES],
  input  logic [NUM_LIT-1:0] neg [LANES],
  input  logic [NUM_LIT-1:0] assignment,
  input  logic [LANES-1:0]   valid,
  output logic               any_fail
`ifdef CLAUSE_FAIL_IDX_EN
  ,
  output logic [OW-1:0]      fail_off
`endif
);

  logic [LANES-1:0] fail;

  // Lanes past the stored clause count are treated as satisfied.
  always_comb begin
    fail = '0;
    for (int l = 0; l < LANES; l++) begin
      fail[l] = valid[l] && !(|((pos[l] & assignment) | (neg[l] & ~assignment)));
    end
  end

  assign any_fail = |fail;

`ifdef CLAUSE_FAIL_IDX_EN
  always_comb begin
    fail_off = '0;
    for (int l = LANES - 1; l >= 0; l--) begin
      if (fail[l]) fail_off = OW'(l);
    end
  end
`endif

endmodule

// File: rtl/clause_store_eval.sv
// Clause register file loaded two words per clause, then scanned LANES clauses per cycle against an assignment.
// Optional feature macro: CLAUSE_FAIL_IDX_EN (registers the lowest failing clause index on fail_idx).
module clause_store_eval import common::*; #(
  parameter int NUM_LIT = number_literal,
  parameter int MAX_CLAUSES = 64,
  parameter int LANES = 1,
  localparam int AW = $clog2(MAX_CLAUSES),
  localparam int CW = AW + 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               load,
  input  logic [NUM_LIT-1:0] i,
  input  logic               eval_start,
  input  logic [NUM_LIT-1:0] assignment,
  output logic               eval_done,
  output logic               eval_sat,
  output logic [AW-1:0]      fail_idx,
  output logic [CW-1:0]      clause_count,
  output logic               overflow,
  output logic               partial
);

  localparam logic [1:0] S_IDLE = 2'(CSE_IDLE);
  localparam logic [1:0] S_LOAD = 2'(CSE_LOAD);
  localparam logic [1:0] S_SCAN = 2'(CSE_SCAN);
  localparam logic [1:0] S_DONE = 2'(CSE_DONE);
  localparam logic [CW-1:0] MAXC = CW'(MAX_CLAUSES);
  localparam logic [CW-1:0] STEP = CW'(LANES);

  logic [1:0]         state;
  logic               neg_phase;
  logic [NUM_LIT-1:0] pos_q;
  logic [NUM_LIT-1:0] asg_q;
  logic [CW-1:0]      idx;
  logic [NUM_LIT-1:0] mem_pos [MAX_CLAUSES];
  logic [NUM_LIT-1:0] mem_neg [MAX_CLAUSES];

  logic [NUM_LIT-1:0] lane_pos [LANES];
  logic [NUM_LIT-1:0] lane_neg [LANES];
  logic [LANES-1:0]   lane_valid;
  logic               any_fail;
  logic               group_last;
  logic               neg_word;

  // The first load-high cycle is itself the POS word, so entry and capture coincide.
  assign neg_word   = load && (state == S_LOAD) && neg_phase;
  assign group_last = (idx + STEP) >= clause_count;
  assign eval_done  = (state == S_DONE);

  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      logic [CW-1:0] li;
      li            = idx + CW'(l);
      lane_pos[l]   = mem_pos[li[AW-1:0]];
      lane_neg[l]   = mem_neg[li[AW-1:0]];
      lane_valid[l] = li < clause_count;
    end
  end

`ifdef CLAUSE_FAIL_IDX_EN
  localparam int OW = (LANES > 1) ? $clog2(LANES) : 1;
  logic [OW-1:0] fail_off;
`endif

  clause_lane_eval #(
    .NUM_LIT(NUM_LIT),
    .LANES  (LANES)
  ) u_lanes (
    .pos       (lane_pos),
    .neg       (lane_neg),
    .assignment(asg_q),
    .valid     (lane_valid),
    .any_fail  (any_fail)
`ifdef CLAUSE_FAIL_IDX_EN
    ,
    .fail_off  (fail_off)
`endif
  );

  always_ff @(posedge clock) begin
    if (neg_word && (clause_count != MAXC)) begin
      mem_pos[clause_count[AW-1:0]] <= pos_q;
      mem_neg[clause_count[AW-1:0]] <= i;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= S_IDLE;
      neg_phase    <= 1'b0;
      pos_q        <= '0;
      asg_q        <= '0;
      idx          <= '0;
      eval_sat     <= 1'b0;
      clause_count <= '0;
      overflow     <= 1'b0;
      partial      <= 1'b0;
    end else if (load) begin
      state <= S_LOAD;
      if (neg_word) begin
        neg_phase <= 1'b0;
        if (clause_count == MAXC) overflow <= 1'b1;
        else clause_count <= clause_count + 1'b1;
      end else begin
        pos_q     <= i;
        neg_phase <= 1'b1;
      end
      // Entering from any other state (including an aborted scan) starts a fresh load.
      if (state != S_LOAD) begin
        clause_count <= '0;
        overflow     <= 1'b0;
        partial      <= 1'b0;
      end
    end else begin
      case (state)
        S_LOAD: begin
          state <= S_IDLE;
          if (neg_phase) partial <= 1'b1;
        end
        S_SCAN: begin
          if (any_fail) begin
            eval_sat <= 1'b0;
            state    <= S_DONE;
          end else if (group_last) begin
            eval_sat <= 1'b1;
            state    <= S_DONE;
          end else begin
            idx <= idx + STEP;
          end
        end
        S_DONE: state <= S_IDLE;
        default: begin
          if (eval_start) begin
            asg_q <= assignment;
            idx   <= '0;
            state <= S_SCAN;
          end
        end
      endcase
    end
  end

`ifdef CLAUSE_FAIL_IDX_EN
  always_ff @(posedge clock) begin
    if (reset) fail_idx <= '0;
    else if (!load && (state == S_SCAN) && any_fail) fail_idx <= idx[AW-1:0] + AW'(fail_off);
  end
`else
  assign fail_idx = '0;
`endif

endmodule

// File: doc/clause_store_eval.md
# clause_store_eval

Parametrised clause memory and evaluation engine for the hardware SAT solver. It captures the clause stream presented on the `load`/`i` interface, two words per clause (positive mask, then negative mask), into an on-chip clause array. It then checks a candidate assignment against all stored clauses, `LANES` clauses per cycle. It sits between the clause-loading front end and the solver search core inside `top`. It replaces the fixed-size, single-clause-per-cycle check.

## Interface
- `NUM_LIT`, default `number_literal` (30): literal count, equal to the word width.
- `MAX_CLAUSES`, default 64: clause array depth.
- `LANES`, default 1: clauses evaluated per cycle. Must be a power of two that divides `MAX_CLAUSES`.

Ports:
- `clock` in, 1: the single clock.
- `reset` in, 1: synchronous, active-high.
- `load` in, 1: high while the clause stream is presented.
- `i` in, `NUM_LIT`: stream word. Bit `NUM_LIT-1` is literal 1; bit 0 is literal `NUM_LIT`.
- `eval_start` in, 1: request an evaluation of `assign`.
- `assign` in, `NUM_LIT`: candidate assignment, same bit order as `i`; 1 means true.
- `eval_done` out, 1: one-cycle completion pulse.
- `eval_sat` out, 1: all clauses satisfied.
- `fail_idx` out, `$clog2(MAX_CLAUSES)`: lowest unsatisfied clause index.
- `clause_count` out, `$clog2(MAX_CLAUSES)+1`: number of clauses stored.
- `overflow` out, 1: sticky; at least one clause was dropped.
- `partial` out, 1: sticky; `load` fell while only a positive mask had been received.

## Operation
- States: IDLE, LOAD, SCAN, DONE. Reset enters IDLE and clears all outputs to 0; array contents are don't-care.

LOAD:
- Entered on `load`=1 from IDLE or DONE.
- Also entered from SCAN when `load`=1; this aborts the scan without a `eval_done` pulse.
- On entry: `clause_count`, `overflow` and `partial` clear to 0; the phase is set to POS.
- POS cycle: latch `i` as the positive mask.
- NEG cycle: write {pos, `i`} to `clause_count`, then increment it.
- If `clause_count`==`MAX_CLAUSES` at a NEG cycle, the clause is dropped and `overflow` is set.
- On `load`=0: go to IDLE. If the phase is NEG, set `partial`; the half clause is discarded.

IDLE:
- `eval_start`=1 with `load`=0 latches `assign`, sets idx=0 and goes to SCAN.
- `eval_start` is ignored in LOAD, SCAN and DONE.

SCAN:
- A clause is satisfied iff `|((pos & assign) | (neg & ~assign))`.
- Each cycle tests clauses idx..idx+LANES-1; indices ≥ `clause_count` count as satisfied.
- Any failure: `eval_sat`=0, `fail_idx` = lowest failing index in the group, go to DONE.
- Else, if idx+LANES ≥ `clause_count`: `eval_sat`=1, go to DONE.
- Else: idx += LANES.
- `clause_count`=0 takes one SCAN cycle and gives sat.

DONE:
- `eval_done`=1 for one cycle, then IDLE.
- `eval_sat` and `fail_idx` hold until the next evaluation completes.

Special clauses:
- Empty clause (both masks 0) is always unsatisfied.
- Tautology (same literal in both masks) is always satisfied.

## Timing
- If `eval_start` is sampled at edge k, SCAN occupies cycles k+1 … k+n, with n = max(1, ceil(`clause_count`/LANES)).
- On an early failure, n is the failing group number plus 1.
- `eval_done` is high in cycle k+n+1.
- A new `eval_start` is accepted at the earliest at the edge ending that DONE cycle's successor (IDLE).
- Loading costs 2 cycles per clause; `clause_count` updates at the edge after the NEG word.
- The array is a register file with combinational read; no read latency.
- `reset` in any state wins over all events.

## Configuration
- `CLAUSE_FAIL_IDX_EN` defined: `fail_idx` is registered as described.
- Not defined: `fail_idx` is tied to 0, and the priority encoder is removed.
- All other behaviour is identical with or without the macro.

## Structure
Package `common` holds:
- `number_literal`
- the state enum `cse_state_t`
- `clause_t`, a struct {pos, neg}, each `NUM_LIT` wide

Sub-module:
- `clause_lane_eval`: combinational; takes `LANES` clauses, `assign` and a valid mask; returns any-fail and the lowest fail offset.
- It is instantiated once.

## Test plan
- **Load/eval sat:** load (x1∨x2), (x1∨x3), (x2∨¬x1∨¬x3), then eval `assign`=110…0.
  - `clause_count`=3 after the last NEG word.
  - `eval_done` 4 cycles after start (LANES=1).
  - `eval_sat`=1.
- **Unsat index:** same clauses, `assign`=100…0 (x1=1, x2=0, x3=0).
  - Clause 2 is satisfied by ¬x3, so this is sat. Then `assign`=101…0 (x1=1, x2=0, x3=1).
  - Required: `eval_sat`=0, `fail_idx`=2, `eval_done` 4 cycles after start.
- **Overflow:** with MAX_CLAUSES=4, stream 5 clauses.
  - `clause_count`=4, `overflow`=1.
  - A new `load` rise clears both.
- **Partial/empty:** stream 3 words, then drop `load`.
  - `partial`=1, `clause_count`=1.
  - If the stored clause is empty (00…0/00…0), eval gives `eval_sat`=0, `fail_idx`=0.
- **Lanes/abort:** with LANES=4, 10 clauses, all satisfied: `eval_done` at k+4.
  - Rerun with `load` raised mid-SCAN: no `eval_done`, state LOAD, `clause_count`=0.
  - Synchronous `reset` mid-SCAN: all outputs 0 next cycle.
